// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the four-requester memory port arbiter.
// The watchdog limit is only consumed when MEM_ARB_WATCHDOG_EN is defined.
package mem_arb_pkg;

  localparam int NUM_REQ        = 4;
  localparam int SEL_W          = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int WDOG_W         = $clog2(TIMEOUT_CYCLES);

  localparam int REQ_IFETCH = 0;
  localparam int REQ_LSU    = 1;
  localparam int REQ_DBG    = 2;
  localparam int REQ_DMA    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the requesters, the shared port and the arbiter.
// The slave modport is the arbiter's view; master is the requester/port side.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               mem_ack;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               mem_valid;
  logic [NUM_REQ-1:0] done;
  logic               timeout;

  modport slave (
    input  req, mem_ack,
    output gnt, sel, mem_valid, done, timeout
  );

  modport master (
    output req, mem_ack,
    input  gnt, sel, mem_valid, done, timeout
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin picker: first unmasked request at or above ptr,
// wrapping modulo four.
module rr_pick4
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [NUM_REQ-1:0] eligible;
  logic [SEL_W-1:0]   cand;

  assign eligible = req & ~mask;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!valid && eligible[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    onehot = valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared 32-bit memory port; holds each grant until
// MEM_ACK. Define MEM_ARB_WATCHDOG_EN to abort grants that never see MEM_ACK.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               timeout_q, timeout_d;

  logic               finish;
  logic               do_grant;
  logic               wdog_hit;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

`ifdef MEM_ARB_WATCHDOG_EN
  logic [WDOG_W-1:0]  wdog_q, wdog_d;

  assign wdog_hit = (state_q == BUSY) && !bus.mem_ack &&
                    (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // The finishing requester is masked only for the arbitration on its own completion edge.
  assign finish    = (state_q == BUSY) && (bus.mem_ack || wdog_hit);
  assign pick_mask = finish ? gnt_q : '0;
  assign do_grant  = pick_valid && ((state_q == IDLE) || finish);

  rr_pick4 u_pick (
    .req    (bus.req),
    .mask   (pick_mask),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    done_d    = '0;
    timeout_d = 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
    wdog_d    = wdog_q;
    if (state_q == BUSY && !finish) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
`endif
    if (finish) begin
      done_d    = bus.mem_ack ? gnt_q : '0;
      timeout_d = wdog_hit;
      state_d   = IDLE;
      gnt_d     = '0;
    end
    if (do_grant) begin
      state_d = BUSY;
      gnt_d   = pick_onehot;
      sel_d   = pick_idx;
      ptr_d   = pick_idx + SEL_W'(1);
`ifdef MEM_ARB_WATCHDOG_EN
      wdog_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
`ifdef MEM_ARB_WATCHDOG_EN
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.mem_valid = |gnt_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, compared
// each cycle with a transaction-level round-robin model (owner/pointer integers).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: the current owner (-1 when idle), the next search start, and the last sel.
  int         m_owner;
  int         m_ptr;
  logic [1:0] m_sel;
  int         m_wd;
  logic [3:0] m_done;
  logic       m_timeout;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] bit_of(input int n);
    logic [3:0] v;
    v = '0;
    if (n >= 0) v[n] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_sel     = 2'd0;
    m_wd      = 0;
    m_done    = '0;
    m_timeout = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic a);
    int w;
    bit ending;
    m_done    = '0;
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      w = pick(r, m_ptr);
      ending = 1'b1;
    end else begin
      ending = a || (WD_EN && (m_wd == TIMEOUT_CYCLES - 1));
      if (ending) begin
        if (a) m_done = bit_of(m_owner);
        else   m_timeout = 1'b1;
        w = pick(r & ~bit_of(m_owner), m_ptr);
      end else begin
        w = -1;
        m_wd++;
      end
    end
    if (ending) begin
      m_owner = w;
      if (w >= 0) begin
        m_ptr = (w + 1) % 4;
        m_sel = 2'(w);
        m_wd  = 0;
      end
    end
  endtask

  task automatic check_output(input string tag);
    logic [3:0] e_gnt;
    e_gnt = bit_of(m_owner);
    tests_run += 5;
    assert (bus.gnt === e_gnt) else begin
      tests_failed++;
      $error("[TB] FAIL %s gnt: got %b expected %b", tag, bus.gnt, e_gnt);
    end
    assert (bus.sel === m_sel) else begin
      tests_failed++;
      $error("[TB] FAIL %s sel: got %0d expected %0d", tag, bus.sel, m_sel);
    end
    assert (bus.mem_valid === (m_owner >= 0)) else begin
      tests_failed++;
      $error("[TB] FAIL %s mem_valid: got %b expected %b", tag, bus.mem_valid, (m_owner >= 0));
    end
    assert (bus.done === m_done) else begin
      tests_failed++;
      $error("[TB] FAIL %s done: got %b expected %b", tag, bus.done, m_done);
    end
    assert (bus.timeout === m_timeout) else begin
      tests_failed++;
      $error("[TB] FAIL %s timeout: got %b expected %b", tag, bus.timeout, m_timeout);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic a, input string tag);
    bus.req     = r;
    bus.mem_ack = a;
    model_step(r, a);
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  initial begin
    logic [3:0] r;
    logic       a;
    logic [3:0] dbg_bit;

    dbg_bit = '0;
    dbg_bit[REQ_DBG] = 1'b1;
    model_reset();
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.mem_ack = 1'b0;
    #3;
    check_output("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full contention from ptr=0 with an ack on every second busy cycle.
    apply_stimulus(4'b1111, 1'b0, "contend_first");
    tests_run++;
    assert (bus.sel === 2'd0) else begin
      tests_failed++;
      $error("[TB] FAIL contend_first_sel: got %0d expected 0", bus.sel);
    end
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(4'b1111, 1'(i % 2), "contend");
    end
    apply_stimulus(4'b0000, 1'b1, "drain");
    apply_stimulus(4'b0000, 1'b1, "drain_idle_ack");

    // Single requester held three cycles, then acknowledged.
    apply_stimulus(4'b0010, 1'b0, "single_grant");
    tests_run++;
    assert (bus.gnt === 4'b0010 && bus.sel === 2'd1) else begin
      tests_failed++;
      $error("[TB] FAIL single_grant_direct: got gnt=%b sel=%0d expected gnt=0010 sel=1", bus.gnt, bus.sel);
    end
    for (int i = 0; i < 3; i++) apply_stimulus(4'b0010, 1'b0, "single_hold");
    apply_stimulus(4'b0000, 1'b1, "single_ack");
    apply_stimulus(4'b0000, 1'b0, "single_idle");

    // Lone requester keeps asserting: re-granted after one idle cycle.
    apply_stimulus(4'b0001, 1'b0, "lone_grant");
    apply_stimulus(4'b0001, 1'b1, "lone_ack");
    apply_stimulus(4'b0001, 1'b0, "lone_regrant");
    apply_stimulus(4'b0000, 1'b1, "lone_done");
    apply_stimulus(4'b0000, 1'b0, "lone_idle");

    // Completion of requester 3 with 0 and 3 waiting wraps to 0.
    apply_stimulus(4'b1000, 1'b0, "wrap_grant3");
    apply_stimulus(4'b1001, 1'b1, "wrap_ack3");
    tests_run++;
    assert (bus.gnt === 4'b0001) else begin
      tests_failed++;
      $error("[TB] FAIL wrap_gnt: got %b expected 0001", bus.gnt);
    end
    apply_stimulus(4'b1000, 1'b1, "wrap_ack0");
    apply_stimulus(4'b0000, 1'b1, "wrap_drain");

    // Request dropped while granted: grant holds until the ack.
    apply_stimulus(4'b0010, 1'b0, "drop_grant");
    for (int i = 0; i < 3; i++) apply_stimulus(4'b0000, 1'b0, "drop_hold");
    apply_stimulus(4'b0000, 1'b1, "drop_ack");
    apply_stimulus(4'b0000, 1'b0, "drop_idle");

    // Long grant with no ack: held forever, or aborted by the watchdog.
    apply_stimulus(4'b0100, 1'b0, "long_grant");
    for (int i = 0; i < 100; i++) begin
      apply_stimulus((i == 20) ? 4'b0101 : 4'b0100, 1'b0, "long_hold");
    end
    apply_stimulus(4'b0000, 1'b1, "long_ack");
    apply_stimulus(4'b0000, 1'b1, "long_drain");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 2) == 0);
      apply_stimulus(r, a, "random");
    end
    for (int i = 0; i < 3; i++) apply_stimulus(4'b0000, 1'b1, "settle");

    // Asynchronous reset mid-transfer while the debug port holds the grant.
    apply_stimulus(dbg_bit, 1'b0, "dbg_grant");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4'b1000, 1'b0, "post_reset_grant");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
